// File: rtl/fpga_board_top.sv
// fpga_board_top -- board-level wrapper for simulation and bring-up.
//
// Synchronises the board reset, holds the internal reset for a stretch
// period, then runs an autonomous memory BIST on a scratch RAM: writes an
// LFSR pattern to every word, reads it back, and compares each word
// against the regenerated pattern. The result is reported on sticky flags.
//
// Ports:
//   clock       in   board clock, all logic on rising edge
//   reset       in   board reset, asynchronous, active-low
//   io_success  out  BIST finished with zero mismatches (sticky until reset)
//   io_fail     out  BIST finished with one or more mismatches (sticky)
//   io_done     out  BIST finished, pass or fail (sticky)
//
// Build option:
//   BOARD_ERR_INJECT_EN -- when defined, the word written to address
//   MEM_DEPTH/2 has bit 0 inverted so the BIST must report a failure.

module fpga_board_top #(
    parameter int unsigned RST_STRETCH = 16,
    parameter int unsigned MEM_DEPTH   = 64,
    parameter int unsigned DATA_W      = 32,
    parameter logic [31:0] LFSR_SEED   = 32'hACE1_2468
) (
    input  logic clock,
    input  logic reset,
    output logic io_success,
    output logic io_fail,
    output logic io_done
);

    localparam int unsigned AW = $clog2(MEM_DEPTH);
    localparam int unsigned CW = (RST_STRETCH > 1) ? $clog2(RST_STRETCH) : 1;

    localparam logic [CW-1:0]     STRETCH_LAST = CW'(RST_STRETCH - 1);
    localparam logic [AW-1:0]     ADDR_LAST    = '1;
    localparam logic [DATA_W-1:0] SEED         = (LFSR_SEED == 32'h0) ? DATA_W'(1) : DATA_W'(LFSR_SEED);
    localparam logic [DATA_W-1:0] TAPS         = DATA_W'(32'h8020_0003);

    typedef enum logic [2:0] {
        STRETCH,
        WRITE,
        READ,
        DRAIN,
        DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic [1:0]        rst_sync;
    logic              rst_n;
    logic [CW-1:0]     stretch_cnt;
    logic [AW-1:0]     addr;
    logic [DATA_W-1:0] lfsr;
    logic [DATA_W-1:0] lfsr_next;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic [DATA_W-1:0] exp_data;
    logic              rd_valid;
    logic              mismatch;
    logic              error;
    logic [15:0]       mismatch_cnt;
    logic [DATA_W-1:0] mem [MEM_DEPTH];

    // Reset synchroniser: asserts asynchronously, releases on the 2nd edge.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rst_sync <= '0;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign rst_n = rst_sync[1];

    always_comb begin
        lfsr_next = {1'b0, lfsr[DATA_W-1:1]} ^ (lfsr[0] ? TAPS : '0);
    end

    always_comb begin
`ifdef BOARD_ERR_INJECT_EN
        wdata = lfsr ^ ((addr == AW'(MEM_DEPTH / 2)) ? DATA_W'(1) : '0);
`else
        wdata = lfsr;
`endif
    end

    // Single-port scratch RAM, read data valid one cycle after the address.
    always_ff @(posedge clock) begin
        if (state == WRITE) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

    assign mismatch = rd_valid && (rdata != exp_data);
    // The saturating count never returns to zero, so it doubles as the sticky flag.
    assign error    = (mismatch_cnt != '0);

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state <= STRETCH;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            STRETCH: if (stretch_cnt == STRETCH_LAST) state_next = WRITE;
            WRITE:   if (addr == ADDR_LAST)           state_next = READ;
            READ:    if (addr == ADDR_LAST)           state_next = DRAIN;
            DRAIN:   state_next = DONE;
            DONE:    state_next = DONE;
            default: state_next = STRETCH;
        endcase
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            stretch_cnt  <= '0;
            addr         <= '0;
            lfsr         <= SEED;
            exp_data     <= '0;
            rd_valid     <= 1'b0;
            mismatch_cnt <= '0;
            io_success   <= 1'b0;
            io_fail      <= 1'b0;
            io_done      <= 1'b0;
        end else begin
            // Expected word travels alongside the read so it lines up with rdata.
            rd_valid <= (state == READ);
            if (state == READ) begin
                exp_data <= lfsr;
            end
            if (mismatch && (mismatch_cnt != '1)) begin
                mismatch_cnt <= mismatch_cnt + 16'd1;
            end
            case (state)
                STRETCH: begin
                    if (stretch_cnt != STRETCH_LAST) begin
                        stretch_cnt <= stretch_cnt + CW'(1);
                    end
                end
                WRITE: begin
                    // Address wraps to 0 at the end, ready for the read pass.
                    addr <= addr + AW'(1);
                    lfsr <= (addr == ADDR_LAST) ? SEED : lfsr_next;
                end
                READ: begin
                    addr <= addr + AW'(1);
                    lfsr <= lfsr_next;
                end
                DRAIN: begin
                    // Final compare happens this cycle, so fold it in directly.
                    io_done    <= 1'b1;
                    io_success <= !(error || mismatch);
                    io_fail    <= error || mismatch;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fpga_board_top.sv
module tb_fpga_board_top;

    logic clock;
    logic reset;
    logic reset2;
    logic io_success, io_fail, io_done;
    logic io_success2, io_fail2, io_done2;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef BOARD_ERR_INJECT_EN
    localparam bit INJ = 1'b1;
`else
    localparam bit INJ = 1'b0;
`endif

    typedef struct {
        int lat;
        bit succ;
        bit fl;
    } exp_t;

    exp_t q1[$];
    exp_t q2[$];

    int cnt1 = 0;
    int cnt2 = 0;
    bit seen1 = 0;
    bit seen2 = 0;

    fpga_board_top dut (
        .clock      (clock),
        .reset      (reset),
        .io_success (io_success),
        .io_fail    (io_fail),
        .io_done    (io_done)
    );

    fpga_board_top #(
        .RST_STRETCH (1),
        .MEM_DEPTH   (2),
        .DATA_W      (32),
        .LFSR_SEED   (32'h0)
    ) dut2 (
        .clock      (clock),
        .reset      (reset2),
        .io_success (io_success2),
        .io_fail    (io_fail2),
        .io_done    (io_done2)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Edges since reset release; cleared by any reset low, however short.
    always @(posedge clock or negedge reset) begin
        if (!reset) cnt1 = 0;
        else        cnt1 = cnt1 + 1;
    end

    always @(posedge clock or negedge reset2) begin
        if (!reset2) cnt2 = 0;
        else         cnt2 = cnt2 + 1;
    end

    // Monitors: pop an expectation whenever a DUT presents a completed result.
    always @(negedge clock) begin
        exp_t e;
        if (!io_done) begin
            seen1 = 0;
        end else if (!seen1) begin
            seen1 = 1;
            if (q1.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL done1_unexpected: io_done rose at edge %0d with nothing expected", cnt1);
            end else begin
                e = q1.pop_front();
                check("done1_latency", cnt1, e.lat);
                check("done1_success", {31'b0, io_success}, {31'b0, e.succ});
                check("done1_fail", {31'b0, io_fail}, {31'b0, e.fl});
            end
        end
    end

    always @(negedge clock) begin
        exp_t e;
        if (!io_done2) begin
            seen2 = 0;
        end else if (!seen2) begin
            seen2 = 1;
            if (q2.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL done2_unexpected: io_done rose at edge %0d with nothing expected", cnt2);
            end else begin
                e = q2.pop_front();
                check("done2_latency", cnt2, e.lat);
                check("done2_success", {31'b0, io_success2}, {31'b0, e.succ});
                check("done2_fail", {31'b0, io_fail2}, {31'b0, e.fl});
            end
        end
    end

    always @(negedge clock) begin
        if (io_success && io_fail) begin
            n_fail++;
            $display("FAIL both_flags: io_success=1 io_fail=1 expected not both");
        end
    end

    task automatic push_main();
        exp_t e;
        e.lat  = 147;
        e.succ = !INJ;
        e.fl   = INJ;
        q1.push_back(e);
    endtask

    task automatic wait_done(input string name);
        for (int i = 0; i < 400 && !io_done; i++) @(negedge clock);
        if (!io_done) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_timeout: io_done=0 expected 1 within 400 cycles", name);
        end
        @(negedge clock);
    endtask

    initial begin
        exp_t e2;
        reset  = 1'b0;
        reset2 = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("reset_success", {31'b0, io_success}, 32'd0);
        check("reset_fail", {31'b0, io_fail}, 32'd0);
        check("reset_done", {31'b0, io_done}, 32'd0);

        // Power-on run, plus the small-parameter instance in parallel.
        push_main();
        e2.lat  = 8;
        e2.succ = !INJ;
        e2.fl   = INJ;
        q2.push_back(e2);
        reset  = 1'b1;
        reset2 = 1'b1;
        wait_done("poweron");
        check("ram_word0", dut.mem[0], 32'hACE1_2468);
        check("ram_word1", dut.mem[1], 32'h5670_9234);
        check("mismatch_cnt", {16'b0, dut.mismatch_cnt}, INJ ? 32'd1 : 32'd0);
        check("small_word0", dut2.mem[0], 32'h0000_0001);
        check("small_word1", dut2.mem[1], INJ ? 32'h8020_0002 : 32'h8020_0003);
        repeat (20) @(negedge clock);
        check("held_success", {31'b0, io_success}, {31'b0, !INJ});
        check("held_done", {31'b0, io_done}, 32'd1);

        // Reset pulse while in DONE.
        reset = 1'b0;
        #1;
        check("donerst_success", {31'b0, io_success}, 32'd0);
        check("donerst_fail", {31'b0, io_fail}, 32'd0);
        check("donerst_done", {31'b0, io_done}, 32'd0);
        @(negedge clock);
        push_main();
        reset = 1'b1;
        wait_done("donerst");

        // Reset in the middle of WRITE; nothing expected from the aborted run.
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        repeat (80) @(posedge clock);
        #1;
        reset = 1'b0;
        #1;
        check("midrst_rst_n", {31'b0, dut.rst_n}, 32'd0);
        check("midrst_done", {31'b0, io_done}, 32'd0);
        repeat (2) @(negedge clock);
        push_main();
        reset = 1'b1;
        wait_done("midrst");

        // Sub-cycle reset glitch while in DONE.
        @(negedge clock);
        #2;
        reset = 1'b0;
        #1;
        check("glitch_rst_n", {31'b0, dut.rst_n}, 32'd0);
        check("glitch_done", {31'b0, io_done}, 32'd0);
        check("glitch_success", {31'b0, io_success}, 32'd0);
        push_main();
        reset = 1'b1;
        wait_done("glitch");

        repeat (2) @(negedge clock);
        check("queue1_empty", q1.size(), 32'd0);
        check("queue2_empty", q2.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at 200000 expected finish");
        $fatal(1);
    end

endmodule
